// File: rtl/ex_stage.sv
// Execute stage: single-cycle R-type ALU plus a 32-iteration shift-add multiplier
// that stalls upstream and emits bubbles downstream while it runs.
module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        RegWrite_in,
    input  logic [5:0]  funct_in,
    input  logic [4:0]  shamt_in,
    input  logic [31:0] Rs_data_in,
    input  logic [31:0] Rt_data_in,
    input  logic [4:0]  RdAddr_in,
    output logic [31:0] ALU_result_out,
    output logic [4:0]  RdAddr_out,
    output logic        RegWrite_out,
    output logic        stall_out
);

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;
    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_MUL = 6'h18;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] a_reg, b_reg, acc;
    logic [4:0]  cnt;
    logic [4:0]  rd_reg;
    logic        rw_reg;

    logic [31:0] alu_res;
    logic        alu_known;
    logic        start_mul;

    assign start_mul = valid_in && (funct_in == F_MUL);

    always_comb begin
        alu_res   = '0;
        alu_known = 1'b1;
        case (funct_in)
            F_ADD:   alu_res = Rs_data_in + Rt_data_in;
            F_SUB:   alu_res = Rs_data_in - Rt_data_in;
            F_AND:   alu_res = Rs_data_in & Rt_data_in;
            F_OR:    alu_res = Rs_data_in | Rt_data_in;
            F_SLT:   alu_res = ($signed(Rs_data_in) < $signed(Rt_data_in)) ? 32'd1 : 32'd0;
            F_SLL:   alu_res = Rt_data_in << shamt_in;
            F_SRL:   alu_res = Rt_data_in >> shamt_in;
            default: alu_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            rd_reg <= '0;
            rw_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start_mul) begin
                        a_reg  <= Rs_data_in;
                        b_reg  <= Rt_data_in;
                        rd_reg <= RdAddr_in;
                        rw_reg <= RegWrite_in;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_MUL: begin
                    if (b_reg[0])
                        acc <= acc + a_reg;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        stall_out      = 1'b0;
        RegWrite_out   = 1'b0;
        ALU_result_out = '0;
        RdAddr_out     = RdAddr_in;
        case (state)
            S_IDLE: begin
                if (start_mul) begin
                    stall_out = 1'b1;
                    state_nxt = S_MUL;
                end else if (valid_in && alu_known) begin
                    ALU_result_out = alu_res;
                    RegWrite_out   = RegWrite_in;
                end
            end
            S_MUL: begin
                stall_out = 1'b1;
                if (cnt == 5'd31)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                ALU_result_out = acc;
                RdAddr_out     = rd_reg;
                RegWrite_out   = rw_reg;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Reset forces quiet outputs combinationally so an abort drops stall at once
        if (!rst_n) begin
            stall_out      = 1'b0;
            RegWrite_out   = 1'b0;
            ALU_result_out = '0;
            RdAddr_out     = '0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against a behavioural instruction-level model.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        RegWrite_in;
    logic [5:0]  funct_in;
    logic [4:0]  shamt_in;
    logic [31:0] Rs_data_in;
    logic [31:0] Rt_data_in;
    logic [4:0]  RdAddr_in;
    logic [31:0] ALU_result_out;
    logic [4:0]  RdAddr_out;
    logic        RegWrite_out;
    logic        stall_out;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .RegWrite_in    (RegWrite_in),
        .funct_in       (funct_in),
        .shamt_in       (shamt_in),
        .Rs_data_in     (Rs_data_in),
        .Rt_data_in     (Rt_data_in),
        .RdAddr_in      (RdAddr_in),
        .ALU_result_out (ALU_result_out),
        .RdAddr_out     (RdAddr_out),
        .RegWrite_out   (RegWrite_out),
        .stall_out      (stall_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Packed view {stall, regwrite, rd, result}
    task automatic expect_outs(input string tag, input bit st, input bit rw,
                               input logic [4:0] rd, input logic [31:0] res);
        check(tag, {25'b0, stall_out, RegWrite_out, RdAddr_out, ALU_result_out},
                   {25'b0, st, rw, rd, res});
    endtask

    task automatic apply(input bit v, input bit rw, input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        valid_in    = v;
        RegWrite_in = rw;
        funct_in    = f;
        shamt_in    = sh;
        Rs_data_in  = a;
        Rt_data_in  = b;
        RdAddr_in   = rd;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Instruction-level reference for the single-cycle operations
    function automatic void ref_single(input logic [5:0] f, input logic [4:0] sh,
                                       input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] r, output bit known);
        logic [63:0] wide;
        known = 1'b1;
        r     = 32'd0;
        case (f)
            6'h20: r = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            6'h22: r = 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h2A: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            6'h00: begin wide = 64'(b) * (64'd1 << sh); r = wide[31:0]; end
            6'h02: r = 32'(64'(b) / (64'd1 << sh));
            default: known = 1'b0;
        endcase
    endfunction

    task automatic do_single(input string tag, input bit v, input bit rw, input logic [5:0] f,
                             input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
        logic [31:0] r;
        bit known;
        apply(v, rw, f, sh, a, b, rd);
        ref_single(f, sh, a, b, r, known);
        @(negedge clk);
        if (v && known) expect_outs(tag, 1'b0, rw, rd, r);
        else            expect_outs(tag, 1'b0, 1'b0, rd, 32'd0);
        advance();
    endtask

    task automatic do_mul(input string tag, input bit rw, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        logic [63:0] prod;
        logic [4:0]  rd_s;
        prod = 64'(a) * 64'(b);
        apply(1'b1, rw, 6'h18, 5'($urandom), a, b, rd);
        @(negedge clk);
        expect_outs({tag, "_start"}, 1'b1, 1'b0, rd, 32'd0);
        advance();
        // Inputs are ignored while iterating, so scramble them
        for (int k = 1; k <= 32; k++) begin
            rd_s = 5'($urandom);
            apply(1'($urandom), 1'($urandom), 6'($urandom), 5'($urandom), $urandom, $urandom, rd_s);
            @(negedge clk);
            expect_outs({tag, "_busy"}, 1'b1, 1'b0, rd_s, 32'd0);
            advance();
        end
        apply(1'b1, rw, 6'h18, 5'd0, a, b, rd);
        @(negedge clk);
        expect_outs({tag, "_done"}, 1'b0, rw, rd, prod[31:0]);
        advance();
    endtask

    task automatic do_instr(input string tag, input bit v, input bit rw, input logic [5:0] f,
                            input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        if (v && f == 6'h18) do_mul(tag, rw, a, b, rd);
        else                 do_single(tag, v, rw, f, sh, a, b, rd);
    endtask

    logic [5:0] f_tab [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h18, 6'h3F};

    initial begin
        rst_n = 1'b0;
        apply(1'b1, 1'b1, 6'h20, 5'd0, 32'd5, 32'd7, 5'd3);
        #2;
        expect_outs("rst_async", 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        expect_outs("rst_hold", 1'b0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        advance();

        do_single("add", 1'b1, 1'b1, 6'h20, 5'd0, 32'd5, 32'd7, 5'd3);
        do_single("sub", 1'b1, 1'b1, 6'h22, 5'd0, 32'd3, 32'd5, 5'd4);
        do_single("slt", 1'b1, 1'b1, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1, 5'd5);
        do_single("srl", 1'b1, 1'b1, 6'h02, 5'd31, 32'd0, 32'h8000_0000, 5'd6);
        do_single("sll", 1'b1, 1'b1, 6'h00, 5'd31, 32'd0, 32'd1, 5'd7);
        do_mul("mul_a", 1'b1, 32'h0001_0001, 32'h0001_0001, 5'd9);
        do_mul("mul_ff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
        do_single("add_after_mul", 1'b1, 1'b1, 6'h20, 5'd0, 32'd1, 32'd1, 5'd11);
        do_mul("mul_zero", 1'b1, 32'd0, 32'h1234_5678, 5'd12);
        do_mul("mul_norw", 1'b0, 32'd6, 32'd7, 5'd13);
        do_mul("mul_b2b", 1'b1, 32'd3, 32'd4, 5'd14);
        do_single("bad_funct", 1'b1, 1'b1, 6'h3F, 5'd0, 32'd9, 32'd9, 5'd15);
        do_single("bubble_mul", 1'b0, 1'b1, 6'h18, 5'd0, 32'd9, 32'd9, 5'd16);

        // Reset in the 11th stall cycle of a multiply aborts it
        apply(1'b1, 1'b1, 6'h18, 5'd0, 32'd100, 32'd200, 5'd17);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            expect_outs("abort_busy", 1'b1, 1'b0, 5'd17, 32'd0);
            advance();
        end
        #1 rst_n = 1'b0;
        #1 expect_outs("abort_rst", 1'b0, 1'b0, 5'd0, 32'd0);
        apply(1'b1, 1'b1, 6'h20, 5'd0, 32'd2, 32'd2, 5'd18);
        #1 rst_n = 1'b1;
        @(negedge clk);
        expect_outs("abort_add", 1'b0, 1'b1, 5'd18, 32'd4);
        advance();
        do_single("abort_no_replay", 1'b0, 1'b1, 6'h18, 5'd0, 32'd0, 32'd0, 5'd19);

        for (int i = 0; i < 150; i++) begin
            logic [5:0] f;
            f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : f_tab[$urandom_range(0, 8)];
            do_instr("rand", $urandom_range(0, 6) != 0, 1'($urandom), f, 5'($urandom),
                     $urandom, $urandom, 5'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
